// File: rtl/car_lamp_ctrl_gen_if.sv
// car_lamp_ctrl_gen_if: driver switches in, lamp bars and status digits out
interface car_lamp_ctrl_gen_if #(parameter int LED_W = 3);
  logic swL, swR, swBrake, swDoor, modeSeq;
  logic [LED_W-1:0] ledL, ledR;
  logic [6:0] ledNum1, ledNum2;
  logic [1:0] lit;
  modport master (output swL, swR, swBrake, swDoor, modeSeq, input ledL, ledR, ledNum1, ledNum2, lit);
  modport slave (input swL, swR, swBrake, swDoor, modeSeq, output ledL, ledR, ledNum1, ledNum2, lit);
endinterface

// File: rtl/car_lamp_ctrl_gen.sv
// car_lamp_ctrl_gen: synchronised four-switch car lamp controller with turn, hazard, brake and door patterns
module car_lamp_ctrl_gen #(
  parameter int LED_W = 3,
  parameter int TICK_DIV = 10_000_000,
  parameter int DOOR_TICKS = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rstN,
  car_lamp_ctrl_gen_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);
  localparam logic [6:0] SEG_0 = 7'b0111111, SEG_1 = 7'b0110000, SEG_H = 7'b1110110;
  localparam logic [6:0] SEG_P = 7'b1110011, SEG_E = 7'b1111001, SEG_DASH = 7'b1000000;
  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZARD, BRAKE, DOOR_ON, DOOR_OFF} stateT;
  stateT state, nextState, req;
  logic [SYNC_STAGES-1:0][4:0] syncQ;
  logic [4:0] s;
  logic [TW-1:0] tickCnt, nextTick;
  logic [DW-1:0] doorCnt, nextDoor;
  logic [LED_W-1:0] ledL, ledR, nextL, nextR;
  logic [6:0] num1, num2, nextNum1, nextNum2;
  logic [1:0] lit;
  logic tick;
  // s = {modeSeq, swDoor, swBrake, swR, swL} after the synchroniser chain
  assign s = syncQ[SYNC_STAGES-1];
  assign tick = tickCnt == TICK_LAST;
  function automatic logic [LED_W-1:0] stepBar(logic [LED_W-1:0] bar, logic fill);
    return fill ? (&bar ? '0 : {bar[LED_W-2:0], 1'b1}) : {bar[LED_W-2:0], bar[LED_W-1]};
  endfunction
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncQ <= '0;
      state <= IDLE;
      tickCnt <= '0;
      doorCnt <= '0;
      ledL <= '0;
      ledR <= '0;
      num1 <= SEG_1;
      num2 <= SEG_1;
      lit <= 2'b00;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], {bus.modeSeq, bus.swDoor, bus.swBrake, bus.swR, bus.swL}};
      state <= nextState;
      tickCnt <= nextTick;
      doorCnt <= nextDoor;
      ledL <= nextL;
      ledR <= nextR;
      num1 <= nextNum1;
      num2 <= nextNum2;
      lit <= 2'b11;
    end
  end
  always_comb begin
    req = s[2] ? BRAKE : &s[1:0] ? HAZARD : s[3] ? DOOR_ON : s[0] ? LEFT : s[1] ? RIGHT : IDLE;
    nextState = req;
    // a held door request never re-arms the courtesy light on its own
    if (req == DOOR_ON && (state == DOOR_ON || state == DOOR_OFF))
      nextState = (state == DOOR_ON && tick && doorCnt == DOOR_LAST) ? DOOR_OFF : state;
    nextTick = tick ? '0 : tickCnt + 1'b1;
    nextDoor = doorCnt;
    nextL = ledL;
    nextR = ledR;
    nextNum1 = num1;
    nextNum2 = num2;
    if (nextState != state) begin
      nextTick = '0;
      nextDoor = '0;
      nextL = nextState == LEFT ? LED_W'(1) : nextState inside {HAZARD, BRAKE, DOOR_ON} ? '1 : '0;
      nextR = nextState == RIGHT ? LED_W'(1) : nextState inside {HAZARD, BRAKE, DOOR_ON} ? '1 : '0;
      nextNum1 = nextState == LEFT ? SEG_0 : nextState inside {IDLE, RIGHT} ? SEG_1 :
                 nextState == HAZARD ? SEG_H : nextState == BRAKE ? SEG_P :
                 nextState == DOOR_ON ? SEG_E : SEG_DASH;
      nextNum2 = nextState == RIGHT ? SEG_0 : nextState == LEFT ? SEG_1 : nextNum1;
    end else if (tick) begin
      if (state == LEFT) nextL = stepBar(ledL, s[4]);
      if (state == RIGHT) nextR = stepBar(ledR, s[4]);
      if (state == HAZARD) begin
        nextL = ~ledL;
        nextR = ~ledL;
      end
      if (state == DOOR_ON) nextDoor = doorCnt + 1'b1;
    end
  end
  assign bus.ledL = ledL;
  assign bus.ledR = ledR;
  assign bus.ledNum1 = num1;
  assign bus.ledNum2 = num2;
  assign bus.lit = lit;
endmodule

// File: tb/tb_car_lamp_ctrl_gen.sv
// tb_car_lamp_ctrl_gen: directed test-plan scenarios plus random switch traffic against a behavioural model
module tb_car_lamp_ctrl_gen;
  localparam int W = 3, TD = 4, DT = 3;
  localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3, M_BRAKE = 4, M_DON = 5, M_DOFF = 6;
  logic clk = 0, rstN = 0;
  always #5 clk = ~clk;
  car_lamp_ctrl_gen_if #(.LED_W(W)) bus ();
  car_lamp_ctrl_gen #(.LED_W(W), .TICK_DIV(TD), .DOOR_TICKS(DT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstN(rstN), .bus(bus));
  int errCnt = 0, chkCnt = 0;
  bit chkEn = 0;
  int mMode, mAge, mDoor;
  logic [W-1:0] mBar;
  logic [1:0] mLit;
  logic [4:0] hist[$];
  task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] digit(int mode, bit right);
    case (mode)
      M_LEFT: return right ? 7'b0110000 : 7'b0111111;
      M_RIGHT: return right ? 7'b0111111 : 7'b0110000;
      M_HAZ: return 7'b1110110;
      M_BRAKE: return 7'b1110011;
      M_DON: return 7'b1111001;
      M_DOFF: return 7'b1000000;
      default: return 7'b0110000;
    endcase
  endfunction
  function automatic logic [W-1:0] lamp(int mode, logic [W-1:0] bar, bit right);
    if (mode == M_HAZ || (mode == (right ? M_RIGHT : M_LEFT))) return bar;
    if (mode == M_BRAKE || mode == M_DON) return '1;
    return '0;
  endfunction
  task automatic enterMode(int m);
    mMode = m;
    mAge = 0;
    mDoor = 0;
    mBar = (m == M_HAZ) ? W'(7) : W'(1);
  endtask
  task automatic modelStep();
    logic [4:0] sv;
    int req, tgt;
    if (!rstN) begin
      enterMode(M_IDLE);
      mLit = 2'b00;
      hist = {5'd0, 5'd0};
      return;
    end
    sv = hist.pop_front();
    hist.push_back({bus.modeSeq, bus.swDoor, bus.swBrake, bus.swR, bus.swL});
    mLit = 2'b11;
    req = sv[2] ? M_BRAKE : (sv[0] && sv[1]) ? M_HAZ : sv[3] ? M_DON : sv[0] ? M_LEFT : sv[1] ? M_RIGHT : M_IDLE;
    tgt = (req == M_DON && (mMode == M_DON || mMode == M_DOFF)) ? mMode : req;
    if (tgt != mMode) enterMode(tgt);
    else begin
      mAge++;
      if (mAge % TD == 0) begin
        if (mMode == M_LEFT || mMode == M_RIGHT) begin
          if (sv[4]) mBar = (mBar == W'(7)) ? W'(0) : W'((int'(mBar) * 2 + 1) % 8);
          else mBar = W'((int'(mBar) * 2) % 8 + int'(mBar) / 4);
        end else if (mMode == M_HAZ) mBar = W'(7) - mBar;
        else if (mMode == M_DON) begin
          mDoor++;
          if (mDoor == DT) enterMode(M_DOFF);
        end
      end
    end
  endtask
  initial begin
    modelStep();
    forever begin
      @(posedge clk or negedge rstN);
      modelStep();
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (chkEn) begin
      checkVal("ledL", bus.ledL, lamp(mMode, mBar, 0));
      checkVal("ledR", bus.ledR, lamp(mMode, mBar, 1));
      checkVal("ledNum1", bus.ledNum1, digit(mMode, 0));
      checkVal("ledNum2", bus.ledNum2, digit(mMode, 1));
      checkVal("lit", bus.lit, mLit);
    end
  end
  task automatic setIn(bit l, bit r, bit b, bit d, bit m);
    bus.swL = l;
    bus.swR = r;
    bus.swBrake = b;
    bus.swDoor = d;
    bus.modeSeq = m;
  endtask
  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    setIn(0, 0, 0, 0, 0);
    chkEn = 1;
    hold(3);
    rstN = 1;
    hold(4);
    setIn(1, 0, 0, 0, 0);
    hold(2);
    checkVal("lat_before", bus.ledL, 0);
    hold(1);
    checkVal("lat_entry", bus.ledL, 1);
    hold(14);
    rstN = 0;
    #1;
    checkVal("arst_ledL", bus.ledL, 0);
    checkVal("arst_num1", bus.ledNum1, 7'b0110000);
    checkVal("arst_lit", bus.lit, 0);
    hold(2);
    rstN = 1;
    setIn(1, 0, 0, 0, 1);
    hold(26);
    setIn(1, 0, 0, 0, 0);
    hold(10);
    setIn(1, 1, 0, 0, 0);
    hold(14);
    setIn(1, 1, 1, 0, 0);
    hold(10);
    setIn(0, 0, 0, 0, 0);
    hold(5);
    setIn(0, 0, 0, 1, 0);
    hold(25);
    checkVal("door_off_ledL", bus.ledL, 0);
    checkVal("door_off_num", bus.ledNum2, 7'b1000000);
    setIn(0, 0, 0, 0, 0);
    hold(1);
    setIn(0, 0, 0, 1, 0);
    hold(20);
    setIn(0, 1, 0, 0, 0);
    hold(8);
    setIn(0, 1, 1, 0, 0);
    hold(1);
    setIn(0, 1, 0, 0, 0);
    hold(12);
    #2 bus.swL = 1;
    #1 bus.swL = 0;
    hold(6);
    repeat (200) begin
      setIn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      hold($urandom_range(1, 20));
    end
    chkEn = 0;
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
